// File: rtl/matmul_pkg.sv
// Shared types and constants for the memory-bank / systolic-MAC datapath.
package matmul_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ACC_W_DEF  = 2 * DATA_W_DEF + 2;
  localparam int MAX_DIM    = 3;
  localparam int N_ELEM     = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    STREAM,
    FINISH,
    WAIT_LOW
  } state_t;

  function automatic logic [3:0] idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return 4'(r) * 4'(MAX_DIM) + 4'(c);
  endfunction

endpackage

// File: rtl/result_index_ctr.sv
// Row-major 2D index counter with wrap-around and last-element detect.
// Shared by the result unloader and the upstream input loader.
module result_index_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] rows,
  input  logic [1:0] cols,
  output logic [1:0] r,
  output logic [1:0] c,
  output logic       last
);

  logic c_end;
  logic r_end;

  assign c_end = (c == cols - 2'd1);
  assign r_end = (r == rows - 2'd1);
  assign last  = c_end && r_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r <= 2'd0;
      c <= 2'd0;
    end else if (en) begin
      if (c_end) begin
        c <= 2'd0;
        r <= r_end ? 2'd0 : r + 2'd1;
      end else begin
        c <= c + 2'd1;
      end
    end
  end

endmodule

// File: rtl/result_unloader.sv
// Snapshots the MAC accumulators and streams rows x cols results out.
// Optional RESULT_SAT_EN: saturate to OUT_W and add sticky sat_flag.
module result_unloader
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = 2 * DATA_W + 2,
  parameter int OUT_W  = ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               unload_res,
  input  logic [9*ACC_W-1:0] mac_res,
  input  logic [1:0]         row_w,
  input  logic [1:0]         col_x,
  input  logic               res_ready,
  output logic               res_valid,
  output logic [OUT_W-1:0]   res_data,
  output logic [1:0]         res_row,
  output logic [1:0]         res_col,
  output logic               res_last,
  output logic               busy,
  output logic               done
`ifdef RESULT_SAT_EN
  ,
  output logic               sat_flag
`endif
);

  state_t state;
  state_t state_n;
  logic   unload_q;

  logic [N_ELEM-1:0][ACC_W-1:0] rbuf;
  logic [1:0]       rows;
  logic [1:0]       cols;
  logic [1:0]       r;
  logic [1:0]       c;
  logic             last;
  logic             xfer;
  logic [ACC_W-1:0] acc;
  logic [OUT_W-1:0] data;
  logic             ovf;

  assign xfer = res_valid && res_ready;
  assign acc  = rbuf[idx(r, c)];

  result_index_ctr u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == CAPTURE),
    .en   (xfer),
    .rows (rows),
    .cols (cols),
    .r    (r),
    .c    (c),
    .last (last)
  );

  generate
    if (OUT_W < ACC_W) begin : g_ovf
      assign ovf = |acc[ACC_W-1:OUT_W];
    end else begin : g_noovf
      assign ovf = 1'b0;
    end
  endgenerate

`ifdef RESULT_SAT_EN
  assign data = ovf ? '1 : acc[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || state == CAPTURE) begin
      sat_flag <= 1'b0;
    end else if (xfer && ovf) begin
      sat_flag <= 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ovf;
  assign data = acc[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      unload_q <= 1'b0;
      rbuf     <= '0;
      rows     <= 2'd0;
      cols     <= 2'd0;
    end else begin
      state    <= state_n;
      unload_q <= unload_res;
      if (state == CAPTURE) begin
        rbuf <= mac_res;
        rows <= row_w;
        cols <= col_x;
      end
    end
  end

  // Decision in CAPTURE uses the dims being latched on this same edge.
  always_comb begin
    state_n   = state;
    res_valid = 1'b0;
    res_data  = '0;
    res_row   = 2'd0;
    res_col   = 2'd0;
    res_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (unload_res && !unload_q) state_n = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (row_w == 2'd0 || col_x == 2'd0) state_n = FINISH;
        else                                state_n = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = data;
        res_row   = r;
        res_col   = c;
        res_last  = last;
        if (res_ready && last) state_n = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!unload_res) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_unloader.sv
// Randomized bench for result_unloader against a queue-based model.
// Build with +define+RESULT_SAT_EN to cover the saturating variant.
module tb_result_unloader;

  localparam int ACC_W = 10;
  localparam int OUT_W = 8;

  localparam int M_RAND  = 0;
  localparam int M_FIXED = 1;
  localparam int M_OVF   = 2;

  localparam int R_ONE = 0;
  localparam int R_TOG = 1;
  localparam int R_RND = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               unload_res;
  logic [9*ACC_W-1:0] mac_res;
  logic [1:0]         row_w;
  logic [1:0]         col_x;
  logic               res_ready;
  logic               res_valid;
  logic [OUT_W-1:0]   res_data;
  logic [1:0]         res_row;
  logic [1:0]         res_col;
  logic               res_last;
  logic               busy;
  logic               done;
`ifdef RESULT_SAT_EN
  logic               sat_flag;
`endif

  result_unloader #(
    .DATA_W (4),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .unload_res (unload_res),
    .mac_res    (mac_res),
    .row_w      (row_w),
    .col_x      (col_x),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_row    (res_row),
    .res_col    (res_col),
    .res_last   (res_last),
    .busy       (busy),
    .done       (done)
`ifdef RESULT_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   exp_done  = 0;
  int   done_seen = 0;
  bit   flag_m    = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_val(input int a);
`ifdef RESULT_SAT_EN
    return (a > 255) ? 255 : a;
`else
    return a % 256;
`endif
  endfunction

  // Compare process: outputs settle after posedge, inputs change at +1.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      flag_m = 1'b0;
    end else begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = exp_q[0];
          chk("data", int'(res_data), e.data);
          chk("row", int'(res_row), e.row);
          chk("col", int'(res_col), e.col);
          chk("last", int'(res_last), int'(e.last));
          chk("busy", int'(busy), 1);
`ifdef RESULT_SAT_EN
          chk("sat_flag", int'(sat_flag), int'(flag_m));
`endif
          if (res_ready) begin
            void'(exp_q.pop_front());
            if (e.sat) flag_m = 1'b1;
          end
        end
      end
      if (done) begin
        done_seen++;
        chk("done_empty", exp_q.size(), 0);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  function automatic bit rdy(input int mode, input int cyc);
    if (mode == R_TOG) return cyc[0];
    if (mode == R_RND) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic start_job(input int rows, input int cols,
                           input int mode, input int rmode);
    int   mac [9];
    exp_t e;
    for (int k = 0; k < 9; k++) begin
      if (mode == M_FIXED) mac[k] = 10 * k + 1;
      else mac[k] = int'($urandom_range(0, 1023));
    end
    if (mode == M_OVF) mac[0] = 300;
    for (int k = 0; k < 9; k++)
      mac_res[k*ACC_W +: ACC_W] = ACC_W'(mac[k]);
    row_w = 2'(rows);
    col_x = 2'(cols);
    flag_m = 1'b0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        e.data = exp_val(mac[r*3+c]);
        e.row  = r;
        e.col  = c;
        e.last = (r == rows - 1) && (c == cols - 1);
        e.sat  = mac[r*3+c] > 255;
        exp_q.push_back(e);
      end
    exp_done++;
    res_ready  = rdy(rmode, 0);
    unload_res = 1'b1;
  endtask

  task automatic run_job(input int rows, input int cols, input int hold,
                         input int mode, input int rmode, input bit scr);
    int  cyc = 0;
    bit  ok  = 1'b0;
    start_job(rows, cols, mode, rmode);
    while (cyc < 300) begin
      @(posedge clk); #1;
      if (cyc + 1 >= hold) unload_res = 1'b0;
      res_ready = rdy(rmode, cyc + 1);
      if (scr && cyc == 2) begin
        mac_res = {$urandom, $urandom, $urandom};
        row_w   = 2'($urandom_range(0, 3));
        col_x   = 2'($urandom_range(0, 3));
      end
      if (cyc == 1) begin
        if (rows * cols == 0) chk("zero_done_lat", int'(done), 1);
        else chk("first_valid_lat", int'(res_valid), 1);
        if (mode == M_FIXED) chk("fixed_first", int'(res_data), 1);
`ifdef RESULT_SAT_EN
        if (mode == M_OVF) chk("ovf_data", int'(res_data), 255);
`else
        if (mode == M_OVF) chk("ovf_data", int'(res_data), 44);
`endif
      end
      if (mode == M_FIXED && rows == 3 && cols == 3) begin
        if (cyc == 9) begin
          chk("fixed_9th", int'(res_data), 81);
          chk("fixed_last", int'(res_last), 1);
        end
        if (cyc == 10) chk("fixed_done", int'(done), 1);
      end
      if (done_seen == exp_done && !unload_res) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    if (!ok) chk("timeout", 0, 1);
    unload_res = 1'b0;
    @(posedge clk); #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic mid_reset();
    start_job(3, 3, M_FIXED, R_ONE);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      unload_res = 1'b0;
    end
    chk("rst_pre_valid", int'(res_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done--;
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_done", done_seen, exp_done);
  endtask

  initial begin
    rst        = 1'b1;
    unload_res = 1'b0;
    res_ready  = 1'b0;
    row_w      = 2'd0;
    col_x      = 2'd0;
    mac_res    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_rc", int'({res_row, res_col}), 0);
    chk("rst_res_last", int'(res_last), 0);
    chk("rst_busy0", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(3, 3, 1, M_FIXED, R_ONE, 1'b0);
    run_job(2, 3, 1, M_RAND, R_TOG, 1'b1);
    run_job(2, 0, 1, M_RAND, R_ONE, 1'b0);
    run_job(1, 1, 40, M_RAND, R_ONE, 1'b0);
    chk("hold_one_done", done_seen, exp_done);
    run_job(1, 1, 1, M_RAND, R_ONE, 1'b0);
    mid_reset();
    run_job(3, 3, 1, M_FIXED, R_ONE, 1'b0);
    run_job(1, 1, 1, M_OVF, R_ONE, 1'b0);
`ifdef RESULT_SAT_EN
    chk("ovf_sat_flag", int'(sat_flag), 1);
`endif
    for (int i = 0; i < 40; i++)
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 6)), M_RAND, R_RND, 1'b1);
    chk("done_count", done_seen, exp_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
